// File: rtl/rv32i_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the RV32I R-type datapath.
// Optional performance counters (cyc_cnt, ret_cnt) are built when SEQ_PERF_CNT_EN is defined.
module rv32i_seq_ctrl #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int unsigned FETCH_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        halt_req,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_o,
   output logic        op_latch,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] pc,
   output logic        busy,
   output logic        retire,
   output logic        illegal,
   output logic        fetch_err
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [31:0] cyc_cnt,
   output logic [31:0] ret_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_HALT,
      S_TRAP
   } state_t;

   // Trap fires in the FETCH cycle whose count (before increment) is FETCH_TIMEOUT-1.
   localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] instr_q;
   logic [7:0]  tmo_q;
   logic [7:0]  tmo_d;
   logic        illegal_q;
   logic        fetch_err_q;
   logic        op_latch_q;
   logic        rf_we_q;
   logic        retire_q;
   logic        busy_q;
   logic        imem_req_q;
   logic        legal_d;

   function automatic logic rtype_legal(input logic [31:0] w);
      logic       opc_ok;
      logic       base_ok;
      logic       alt_ok;
      opc_ok  = (w[6:0] == 7'b0110011);
      base_ok = (w[31:25] == 7'b0000000);
      alt_ok  = (w[31:25] == 7'b0100000) && ((w[14:12] == 3'b000) || (w[14:12] == 3'b101));
      return opc_ok && (base_ok || alt_ok);
   endfunction

   assign pc_d    = pc_q + 32'd4;
   assign tmo_d   = tmo_q + 8'd1;
   assign legal_d = rtype_legal(instr_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         instr_q     <= '0;
         tmo_q       <= '0;
         illegal_q   <= 1'b0;
         fetch_err_q <= 1'b0;
         op_latch_q  <= 1'b0;
         rf_we_q     <= 1'b0;
         retire_q    <= 1'b0;
         busy_q      <= 1'b0;
         imem_req_q  <= 1'b0;
      end else begin
         op_latch_q <= 1'b0;
         rf_we_q    <= 1'b0;
         retire_q   <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (halt_req) begin
                  state_q <= S_HALT;
               end else if (start) begin
                  state_q    <= S_FETCH;
                  busy_q     <= 1'b1;
                  imem_req_q <= 1'b1;
               end
            end
            S_FETCH: begin
               // A word arriving on the last allowed cycle is still accepted.
               if (imem_valid) begin
                  instr_q    <= imem_rdata;
                  tmo_q      <= '0;
                  imem_req_q <= 1'b0;
                  state_q    <= S_DECODE;
               end else if (tmo_q == TMO_LAST) begin
                  tmo_q       <= tmo_d;
                  fetch_err_q <= 1'b1;
                  imem_req_q  <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= S_TRAP;
               end else begin
                  tmo_q <= tmo_d;
               end
            end
            S_DECODE: begin
               if (legal_d) begin
                  op_latch_q <= 1'b1;
                  state_q    <= S_EXEC;
               end else begin
                  illegal_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= S_TRAP;
               end
            end
            S_EXEC: begin
               retire_q <= 1'b1;
               rf_we_q  <= (instr_q[11:7] != 5'd0);
               state_q  <= S_WB;
            end
            S_WB: begin
               pc_q <= pc_d;
               if (halt_req) begin
                  busy_q  <= 1'b0;
                  state_q <= S_HALT;
               end else begin
                  imem_req_q <= 1'b1;
                  state_q    <= S_FETCH;
               end
            end
            S_HALT: begin
               if (start && !halt_req) begin
                  busy_q     <= 1'b1;
                  imem_req_q <= 1'b1;
                  state_q    <= S_FETCH;
               end
            end
            S_TRAP: begin
               state_q <= S_TRAP;
            end
            default: begin
               busy_q     <= 1'b0;
               imem_req_q <= 1'b0;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

   assign imem_req  = imem_req_q;
   assign imem_addr = pc_q;
   assign instr_o   = instr_q;
   assign op_latch  = op_latch_q;
   assign rf_we     = rf_we_q;
   assign rf_waddr  = instr_q[11:7];
   assign pc        = pc_q;
   assign busy      = busy_q;
   assign retire    = retire_q;
   assign illegal   = illegal_q;
   assign fetch_err = fetch_err_q;

`ifdef SEQ_PERF_CNT_EN
   logic [31:0] cyc_cnt_q;
   logic [31:0] ret_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cyc_cnt_q <= '0;
         ret_cnt_q <= '0;
      end else begin
         if (busy_q) begin
            cyc_cnt_q <= cyc_cnt_q + 32'd1;
         end
         if (retire_q) begin
            ret_cnt_q <= ret_cnt_q + 32'd1;
         end
      end
   end

   assign cyc_cnt = cyc_cnt_q;
   assign ret_cnt = ret_cnt_q;
`endif

endmodule

// File: tb/tb_rv32i_seq_ctrl.sv
// Scoreboard bench for rv32i_seq_ctrl: retire records queued at fetch, checked on each retire pulse.
module tb_rv32i_seq_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        halt_req;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid;
   logic [31:0] imem_rdata;
   logic [31:0] instr_o;
   logic        op_latch;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] pc;
   logic        busy;
   logic        retire;
   logic        illegal;
   logic        fetch_err;
`ifdef SEQ_PERF_CNT_EN
   logic [31:0] cyc_cnt;
   logic [31:0] ret_cnt;
`endif

   rv32i_seq_ctrl #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .halt_req  (halt_req),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_valid(imem_valid),
      .imem_rdata(imem_rdata),
      .instr_o   (instr_o),
      .op_latch  (op_latch),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .pc        (pc),
      .busy      (busy),
      .retire    (retire),
      .illegal   (illegal),
      .fetch_err (fetch_err)
`ifdef SEQ_PERF_CNT_EN
      ,
      .cyc_cnt   (cyc_cnt),
      .ret_cnt   (ret_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        we;
      logic [4:0]  waddr;
   } ret_t;

   ret_t        sb[$];
   ret_t        mon_e;
   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_pc;

   function automatic bit model_legal(input logic [31:0] w);
      logic [9:0] f73;
      f73 = {w[31:25], w[14:12]};
      if (w[6:0] != 7'h33) return 1'b0;
      if (w[31:25] == 7'h00) return 1'b1;
      return (f73 == 10'b0100000_000) || (f73 == 10'b0100000_101);
   endfunction

   // Retire monitor: every retire pulse must match the oldest queued record.
   always @(negedge clk) begin
      if (retire === 1'b1) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL spurious_retire pc=%h we=%0b waddr=%0d required no retire", pc, rf_we, rf_waddr);
         end else begin
            mon_e = sb.pop_front();
            if (rf_we !== mon_e.we || rf_waddr !== mon_e.waddr || pc !== mon_e.pc) begin
               bad++;
               $display("FAIL retire_record got pc=%h we=%0b waddr=%0d want pc=%h we=%0b waddr=%0d",
                        pc, rf_we, rf_waddr, mon_e.pc, mon_e.we, mon_e.waddr);
            end
         end
      end else if (rf_we === 1'b1) begin
         total++;
         bad++;
         $display("FAIL rf_we_without_retire got rf_we=1 want 0");
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset      = 1'b0;
      start      = 1'b0;
      halt_req   = 1'b0;
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      step();
      step();
      reset  = 1'b1;
      exp_pc = 32'h0;
      sb.delete();
      step();
   endtask

   task automatic go();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Entered in a FETCH cycle; leaves in the cycle after WB (or in TRAP for illegal words).
   task automatic run_instr(input logic [31:0] word, input bit halt_at_exec);
      bit   lg;
      ret_t r;
      lg = model_legal(word);
      total++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
         bad++;
         $display("FAIL fetch_req got req=%0b addr=%h want req=1 addr=%h", imem_req, imem_addr, exp_pc);
      end
      imem_valid = 1'b1;
      imem_rdata = word;
      if (lg) begin
         r.pc    = exp_pc;
         r.we    = (word[11:7] != 5'd0);
         r.waddr = word[11:7];
         sb.push_back(r);
      end
      step();
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      total++;
      if (instr_o !== word || busy !== 1'b1 || op_latch !== 1'b0 || imem_req !== 1'b0) begin
         bad++;
         $display("FAIL decode_cycle got instr=%h busy=%0b op=%0b req=%0b want instr=%h busy=1 op=0 req=0",
                  instr_o, busy, op_latch, imem_req, word);
      end
      step();
      if (!lg) begin
         total++;
         if (illegal !== 1'b1 || busy !== 1'b0 || op_latch !== 1'b0 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL illegal_trap got ill=%0b busy=%0b op=%0b req=%0b want ill=1 busy=0 op=0 req=0",
                     illegal, busy, op_latch, imem_req);
         end
         return;
      end
      total++;
      if (op_latch !== 1'b1 || rf_we !== 1'b0 || retire !== 1'b0) begin
         bad++;
         $display("FAIL exec_cycle got op=%0b we=%0b ret=%0b want op=1 we=0 ret=0", op_latch, rf_we, retire);
      end
      halt_req = halt_at_exec;
      step();
      total++;
      if (op_latch !== 1'b0 || busy !== 1'b1 || pc !== exp_pc) begin
         bad++;
         $display("FAIL wb_cycle got op=%0b busy=%0b pc=%h want op=0 busy=1 pc=%h", op_latch, busy, pc, exp_pc);
      end
      step();
      halt_req = 1'b0;
      exp_pc   = exp_pc + 32'd4;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL retire_missing got pending=%0d want 0", sb.size());
      end
      total++;
      if (pc !== exp_pc || busy !== ~halt_at_exec || imem_req !== ~halt_at_exec) begin
         bad++;
         $display("FAIL after_wb got pc=%h busy=%0b req=%0b want pc=%h busy=%0b req=%0b",
                  pc, busy, imem_req, exp_pc, ~halt_at_exec, ~halt_at_exec);
      end
   endtask

   task automatic test_reset();
      reset      = 1'b0;
      start      = 1'b0;
      halt_req   = 1'b0;
      imem_valid = 1'b0;
      imem_rdata = 32'h0;
      step();
      total++;
      if (pc !== 32'h0 || instr_o !== 32'h0 || busy !== 1'b0 || imem_req !== 1'b0 || op_latch !== 1'b0 ||
          rf_we !== 1'b0 || retire !== 1'b0 || illegal !== 1'b0 || fetch_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_state got pc=%h instr=%h busy=%0b req=%0b op=%0b we=%0b ret=%0b ill=%0b ferr=%0b want all 0",
                  pc, instr_o, busy, imem_req, op_latch, rf_we, retire, illegal, fetch_err);
      end
`ifdef SEQ_PERF_CNT_EN
      total++;
      if (cyc_cnt !== 32'd0 || ret_cnt !== 32'd0) begin
         bad++;
         $display("FAIL reset_perf got cyc=%0d ret=%0d want 0 0", cyc_cnt, ret_cnt);
      end
`endif
   endtask

   task automatic test_add();
      apply_reset();
      go();
      run_instr(32'h002081B3, 1'b1);
   endtask

   task automatic test_back_to_back();
      logic [31:0] words [4];
      words[0] = 32'h4020D2B3;
      words[1] = 32'h0041C3B3;
      words[2] = 32'h01DF7FB3;
      words[3] = 32'h002081B3;
      apply_reset();
      go();
      run_instr(32'h40110233, 1'b0);
      run_instr(32'h00208033, 1'b1);
      go();
      for (int i = 0; i < 4; i++) begin
         run_instr(words[i], (i == 3));
      end
   endtask

   task automatic test_illegal();
      logic [31:0] words [3];
      logic [31:0] trap_pc;
      words[0] = 32'h00000013;
      words[1] = 32'h40209033;
      words[2] = 32'h02208033;
      for (int i = 0; i < 3; i++) begin
         apply_reset();
         go();
         if (i == 2) run_instr(32'h002081B3, 1'b0);
         trap_pc = exp_pc;
         run_instr(words[i], 1'b0);
         start = 1'b1;
         step();
         step();
         start = 1'b0;
         step();
         total++;
         if (busy !== 1'b0 || imem_req !== 1'b0 || pc !== trap_pc || instr_o !== words[i] ||
             illegal !== 1'b1 || fetch_err !== 1'b0) begin
            bad++;
            $display("FAIL trap_hold got busy=%0b req=%0b pc=%h instr=%h ill=%0b ferr=%0b want 0 0 %h %h 1 0",
                     busy, imem_req, pc, instr_o, illegal, fetch_err, trap_pc, words[i]);
         end
      end
   endtask

   task automatic test_timeout();
      apply_reset();
      go();
      for (int i = 1; i < 16; i++) begin
         imem_rdata = $urandom;
         total++;
         if (imem_req !== 1'b1 || fetch_err !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL fetch_wait cyc=%0d got req=%0b ferr=%0b busy=%0b want 1 0 1", i, imem_req, fetch_err, busy);
         end
         step();
      end
      total++;
      if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin
         bad++;
         $display("FAIL fetch_cyc16 got ferr=%0b req=%0b want 0 1", fetch_err, imem_req);
      end
      step();
      start = 1'b1;
      total++;
      if (fetch_err !== 1'b1 || busy !== 1'b0 || imem_req !== 1'b0 || illegal !== 1'b0) begin
         bad++;
         $display("FAIL fetch_trap got ferr=%0b busy=%0b req=%0b ill=%0b want 1 0 0 0", fetch_err, busy, imem_req, illegal);
      end
      step();
      step();
      start = 1'b0;
      total++;
      if (busy !== 1'b0 || imem_req !== 1'b0 || pc !== 32'h0) begin
         bad++;
         $display("FAIL fetch_trap_hold got busy=%0b req=%0b pc=%h want 0 0 0", busy, imem_req, pc);
      end
      apply_reset();
      go();
      for (int i = 1; i < 16; i++) step();
      run_instr(32'h002081B3, 1'b1);
      total++;
      if (fetch_err !== 1'b0) begin
         bad++;
         $display("FAIL fetch_valid_at_limit got ferr=%0b want 0", fetch_err);
      end
   endtask

   task automatic test_halt();
      apply_reset();
      halt_req = 1'b1;
      start    = 1'b1;
      step();
      step();
      total++;
      if (busy !== 1'b0 || imem_req !== 1'b0) begin
         bad++;
         $display("FAIL halt_priority got busy=%0b req=%0b want 0 0", busy, imem_req);
      end
      halt_req = 1'b0;
      step();
      start = 1'b0;
      run_instr(32'h002081B3, 1'b1);
      step();
      total++;
      if (busy !== 1'b0 || pc !== 32'd4) begin
         bad++;
         $display("FAIL halt_hold got busy=%0b pc=%h want 0 00000004", busy, pc);
      end
      go();
      run_instr(32'h40110233, 1'b1);
   endtask

   task automatic test_reset_mid_exec();
      apply_reset();
      go();
      run_instr(32'h002081B3, 1'b0);
      imem_valid = 1'b1;
      imem_rdata = 32'h40110233;
      step();
      imem_valid = 1'b0;
      step();
      total++;
      if (op_latch !== 1'b1 || pc !== 32'd4) begin
         bad++;
         $display("FAIL pre_reset_exec got op=%0b pc=%h want 1 00000004", op_latch, pc);
      end
      #2;
      reset = 1'b0;
      #1;
      total++;
      if (op_latch !== 1'b0 || pc !== 32'h0 || instr_o !== 32'h0 || busy !== 1'b0 || imem_req !== 1'b0 ||
          rf_we !== 1'b0 || retire !== 1'b0) begin
         bad++;
         $display("FAIL async_reset got op=%0b pc=%h instr=%h busy=%0b req=%0b we=%0b ret=%0b want all 0",
                  op_latch, pc, instr_o, busy, imem_req, rf_we, retire);
      end
      step();
      reset = 1'b1;
      step();
      step();
      total++;
      if (busy !== 1'b0 || pc !== 32'h0) begin
         bad++;
         $display("FAIL post_reset_idle got busy=%0b pc=%h want 0 0", busy, pc);
      end
   endtask

`ifdef SEQ_PERF_CNT_EN
   task automatic test_perf();
      apply_reset();
      go();
      run_instr(32'h002081B3, 1'b0);
      run_instr(32'h40110233, 1'b0);
      run_instr(32'h0041C3B3, 1'b1);
      step();
      total++;
      if (ret_cnt !== 32'd3 || cyc_cnt !== 32'd12) begin
         bad++;
         $display("FAIL perf_counts got ret=%0d cyc=%0d want 3 12", ret_cnt, cyc_cnt);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_illegal();
      test_timeout();
      test_halt();
      test_reset_mid_exec();
`ifdef SEQ_PERF_CNT_EN
      test_perf();
`endif
      step();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain got pending=%0d want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
